// File: rtl/router_pkg.sv
// Shared router encoding: flit info codes, field offsets, START address and
// the root controller's FSM state type.
package router_pkg;

    localparam logic [3:0] INFO_CONFIG   = 4'h1;
    localparam logic [3:0] INFO_READ     = 4'h2;
    localparam logic [3:0] INFO_CALC     = 4'h3;
    localparam logic [3:0] INFO_FIN_BC   = 4'h4;
    localparam logic [3:0] INFO_FIN_CP   = 4'h5;

    // Host write to this address (all-ones, truncated to ADDR_W) starts a run.
    localparam logic [63:0] START_ADDR = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIN_BC,
        ST_WAIT_BC,
        ST_FIN_CP,
        ST_WAIT_CP
    } root_state_e;

    function automatic int flit_info_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int flit_addr_lsb(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO; dout is the head entry whenever !empty.
module fifo_sync #(
    parameter int BIT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [BIT_WIDTH-1:0] din,
    input  logic                 pop,
    output logic [BIT_WIDTH-1:0] dout,
    output logic                 empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 full, do_push, do_pop;

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/quadtree_root_ctrl.sv
// Root LOCAL-port controller: host requests -> CONFIG/READ/CALC flits, per-layer
// FIN phase tracking, credit flow both ways and a held read-return stage.
module quadtree_root_ctrl
    import router_pkg::*;
#(
    parameter int NUM_PE     = 64,
    parameter int INFO_W     = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_ADDR_W  = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int LAYER_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write_en,
    input  logic [ADDR_W-1:0]           write_addr,
    input  logic [DATA_W-1:0]           write_data,
    output logic                        write_rdy,
    input  logic                        read_en,
    input  logic [ADDR_W-1:0]           read_addr,
    output logic                        read_rdy,
    output logic                        read_data_vld,
    output logic [RD_ADDR_W+DATA_W-1:0] read_data,
    input  logic                        read_data_rdy,
    input  logic                        in_data_valid,
    input  logic [INFO_W+ADDR_W+DATA_W-1:0] in_data,
    output logic                        upstream_credit,
    output logic                        out_data_valid,
    output logic [INFO_W+ADDR_W+DATA_W-1:0] out_data,
    input  logic                        downstream_credit,
    output logic                        busy,
    output logic [LAYER_W-1:0]          layer_idx,
    output logic                        interrupt,
    output logic                        irq_status,
    input  logic                        irq_clr,
    input  logic                        abort
);
    localparam int FW       = INFO_W + ADDR_W + DATA_W;
    localparam int RW       = RD_ADDR_W + DATA_W;
    localparam int PW       = $clog2(NUM_PE);
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam int OW       = $clog2(2 * FIFO_DEPTH + 1);
    localparam int INFO_LSB = flit_info_lsb(ADDR_W, DATA_W);
    localparam int ADDR_LSB = flit_addr_lsb(DATA_W);

    root_state_e          state_q, state_d;
    logic [PW-1:0]        pe_cnt_q, pe_cnt_d;
    logic [LAYER_W-1:0]   layer_idx_q, layer_idx_d, layer_no_q, layer_no_d, last_layer;
    logic [CW-1:0]        credit_q, credit_d;
    logic [OW-1:0]        owed_q, owed_d;
    logic                 rdy_q, rdy_d, irq_q, irq_d, irq_sts_q, irq_sts_d, up_q, up_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [RW-1:0]        rd_data_q, rd_data_d;
    logic                 emit, cp_done, has_credit, wr_acc, rd_acc;
    logic [FW-1:0]        flit;
    logic [INFO_W-1:0]    in_info;
    logic                 in_read, in_fin_bc, in_fin_cp;
    logic                 fifo_pop, fifo_empty;
    logic [RW-1:0]        fifo_dout;
    logic                 unused_in;

    function automatic logic [FW-1:0] mk_flit(input logic [3:0] code,
                                               input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] d);
        return {INFO_W'(code), a, d};
    endfunction

    assign in_info    = in_data[INFO_LSB +: INFO_W];
    assign in_read    = in_data_valid && (in_info == INFO_W'(INFO_READ));
    assign in_fin_bc  = in_data_valid && (in_info == INFO_W'(INFO_FIN_BC));
    assign in_fin_cp  = in_data_valid && (in_info == INFO_W'(INFO_FIN_CP));
    assign unused_in  = ^in_data;
    assign has_credit = credit_q != '0;
    // Write wins: read_rdy is masked combinationally by a pending write.
    assign wr_acc     = write_en && rdy_q;
    assign rd_acc     = read_en && rdy_q && !write_en;
    assign last_layer = (layer_no_q == '0) ? '0 : layer_no_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        pe_cnt_d    = pe_cnt_q;
        layer_idx_d = layer_idx_q;
        layer_no_d  = layer_no_q;
        emit        = 1'b0;
        cp_done     = 1'b0;
        flit        = '0;
        irq_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_acc) begin
                    emit = 1'b1;
                    if (write_addr == ADDR_W'(START_ADDR)) begin
                        flit        = mk_flit(INFO_CALC, '0, '0);
                        layer_idx_d = '0;
                        pe_cnt_d    = '0;
                        state_d     = ST_FIN_BC;
                    end else begin
                        flit = mk_flit(INFO_CONFIG, write_addr, write_data);
                        if (write_addr == '0) layer_no_d = write_data[LAYER_W-1:0];
                    end
                end else if (rd_acc) begin
                    emit = 1'b1;
                    flit = mk_flit(INFO_READ, read_addr, '0);
                end
            end
            ST_FIN_BC: begin
                if (in_fin_bc) begin
                    if (pe_cnt_q == PW'(NUM_PE - 1)) begin
                        pe_cnt_d = '0;
                        if (has_credit) begin
                            emit    = 1'b1;
                            flit    = mk_flit(INFO_FIN_BC, '0, '0);
                            state_d = ST_FIN_CP;
                        end else begin
                            state_d = ST_WAIT_BC;
                        end
                    end else begin
                        pe_cnt_d = pe_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_BC: begin
                if (has_credit) begin
                    emit    = 1'b1;
                    flit    = mk_flit(INFO_FIN_BC, '0, '0);
                    state_d = ST_FIN_CP;
                end
            end
            ST_FIN_CP: begin
                if (in_fin_cp) begin
                    if (pe_cnt_q == PW'(NUM_PE - 1)) begin
                        pe_cnt_d = '0;
                        if (has_credit) cp_done = 1'b1;
                        else            state_d = ST_WAIT_CP;
                    end else begin
                        pe_cnt_d = pe_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_CP: cp_done = has_credit;
            default:    state_d = ST_IDLE;
        endcase
        if (cp_done) begin
            emit = 1'b1;
            flit = mk_flit(INFO_FIN_CP, '0, '0);
            if (layer_idx_q == last_layer) begin
                state_d = ST_IDLE;
                irq_d   = 1'b1;
            end else begin
                layer_idx_d = layer_idx_q + 1'b1;
                state_d     = ST_FIN_BC;
            end
        end
        // Abort drops the run silently; credit bookkeeping is left intact.
        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            pe_cnt_d    = '0;
            layer_idx_d = '0;
            emit        = 1'b0;
            flit        = '0;
            irq_d       = 1'b0;
        end
    end

    // READ return credits are withheld until the FIFO pops, so it cannot overflow.
    always_comb begin
        fifo_pop  = !fifo_empty && (!rd_vld_q || read_data_rdy);
        rd_vld_d  = rd_vld_q;
        rd_data_d = rd_data_q;
        if (fifo_pop) begin
            rd_vld_d  = 1'b1;
            rd_data_d = fifo_dout;
        end else if (read_data_rdy) begin
            rd_vld_d  = 1'b0;
        end
        credit_d  = credit_q - CW'(emit) + CW'(downstream_credit);
        rdy_d     = (credit_d != '0) && (state_d == ST_IDLE);
        owed_d    = owed_q + OW'(in_data_valid && !in_read) + OW'(fifo_pop) - OW'(owed_q != '0);
        up_d      = owed_q != '0;
        irq_sts_d = irq_q || (irq_sts_q && !irq_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pe_cnt_q    <= '0;
            layer_idx_q <= '0;
            layer_no_q  <= '0;
            credit_q    <= CW'(FIFO_DEPTH);
            owed_q      <= '0;
            rdy_q       <= 1'b0;
            irq_q       <= 1'b0;
            irq_sts_q   <= 1'b0;
            up_q        <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            pe_cnt_q    <= pe_cnt_d;
            layer_idx_q <= layer_idx_d;
            layer_no_q  <= layer_no_d;
            credit_q    <= credit_d;
            owed_q      <= owed_d;
            rdy_q       <= rdy_d;
            irq_q       <= irq_d;
            irq_sts_q   <= irq_sts_d;
            up_q        <= up_d;
            rd_vld_q    <= rd_vld_d;
            rd_data_q   <= rd_data_d;
        end
    end

    fifo_sync #(
        .BIT_WIDTH (RW),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_ret_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (in_read),
        .din  ({in_data[ADDR_LSB +: RD_ADDR_W], in_data[DATA_W-1:0]}),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .empty(fifo_empty)
    );

    assign write_rdy       = rdy_q;
    assign read_rdy        = rdy_q && !write_en;
    assign out_data_valid  = emit;
    assign out_data        = flit;
    assign upstream_credit = up_q;
    assign read_data_vld   = rd_vld_q;
    assign read_data       = rd_data_q;
    assign busy            = state_q != ST_IDLE;
    assign layer_idx       = layer_idx_q;
    assign interrupt       = irq_q;
    assign irq_status      = irq_sts_q;

endmodule

// File: tb/tb_quadtree_root_ctrl.sv
// Bench for quadtree_root_ctrl: vector table, random host traffic against a
// credit/flit model, and directed multi-cycle sequences.
module tb_quadtree_root_ctrl;
    import router_pkg::*;

    localparam int FD = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        write_en = 0, read_en = 0, read_data_rdy = 0, in_data_valid = 0;
    logic        downstream_credit = 0, irq_clr = 0, abort = 0;
    logic [15:0] write_addr = 0, write_data = 0, read_addr = 0;
    logic [35:0] in_data = 0;
    logic        write_rdy, read_rdy, read_data_vld, upstream_credit, out_data_valid;
    logic        busy, interrupt, irq_status;
    logic [27:0] read_data;
    logic [35:0] out_data;
    logic [3:0]  layer_idx;

    quadtree_root_ctrl dut (
        .clk(clk), .rst(rst),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_rdy(write_rdy),
        .read_en(read_en), .read_addr(read_addr), .read_rdy(read_rdy),
        .read_data_vld(read_data_vld), .read_data(read_data), .read_data_rdy(read_data_rdy),
        .in_data_valid(in_data_valid), .in_data(in_data), .upstream_credit(upstream_credit),
        .out_data_valid(out_data_valid), .out_data(out_data), .downstream_credit(downstream_credit),
        .busy(busy), .layer_idx(layer_idx), .interrupt(interrupt), .irq_status(irq_status),
        .irq_clr(irq_clr), .abort(abort)
    );

    always #5 clk = ~clk;

    // Observation side: sole writer of everything recorded here.
    logic [35:0] flits[$];
    logic [27:0] rd_q[$];
    int          up_stamps[$];
    int          cyc = 0, up_cnt = 0, irq_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (out_data_valid) flits.push_back(out_data);
            if (upstream_credit) begin up_cnt++; up_stamps.push_back(cyc); end
            if (interrupt) irq_cnt++;
            if (read_data_vld && read_data_rdy) rd_q.push_back(read_data);
        end
    end

    int n_cmp = 0, n_err = 0;
    bit auto_dc = 0;
    int auto_base = 0, returned = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: pulse inputs drop, router model hands back one credit per flit seen.
    task automatic step();
        @(posedge clk); #1;
        write_en = 0; read_en = 0; in_data_valid = 0; abort = 0; irq_clr = 0;
        downstream_credit = 0;
        if (auto_dc && (flits.size() - auto_base > returned)) begin
            downstream_credit = 1; returned++;
        end
    endtask

    task automatic auto_on();
        auto_base = flits.size(); returned = 0; auto_dc = 1;
    endtask

    function automatic logic [35:0] mk(input logic [3:0] c, input logic [15:0] a, input logic [15:0] d);
        return {c, a, d};
    endfunction

    task automatic send(input logic [3:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            step(); in_data_valid = 1; in_data = mk(code, 16'h0, 16'h0);
        end
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [15:0] d);
        step(); write_en = 1; write_addr = a; write_data = d;
    endtask

    task automatic give_credits(input int n);
        for (int i = 0; i < n; i++) begin step(); downstream_credit = 1; end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] wa, wd;
        logic        re;
        logic [15:0] ra;
        logic        exp_v;
        logic [35:0] exp_f;
        logic        exp_rrdy;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fb, ub, ib, rb, sb;
        int m_credit;
        bit m_rdy, we, re, dc, wacc, racc;
        logic [15:0] wa, wd, ra;
        logic [35:0] ef;

        tbl[0] = '{1, 16'h0000, 16'h0002, 0, 16'h0,    1, mk(INFO_CONFIG, 16'h0000, 16'h0002), 0};
        tbl[1] = '{1, 16'h0010, 16'h1234, 0, 16'h0,    1, mk(INFO_CONFIG, 16'h0010, 16'h1234), 0};
        tbl[2] = '{0, 16'h0,    16'h0,    1, 16'h0ABC, 1, mk(INFO_READ,   16'h0ABC, 16'h0000), 1};
        tbl[3] = '{1, 16'h0020, 16'h0055, 1, 16'h0777, 1, mk(INFO_CONFIG, 16'h0020, 16'h0055), 0};
        tbl[4] = '{0, 16'h0,    16'h0,    0, 16'h0,    0, 36'h0,                               1};
        tbl[5] = '{1, 16'h0000, 16'h0001, 0, 16'h0,    1, mk(INFO_CONFIG, 16'h0000, 16'h0001), 0};

        // Reset state
        #2;
        chk("rst_write_rdy", 64'(write_rdy), 0);
        chk("rst_read_rdy", 64'(read_rdy), 0);
        chk("rst_out_valid", 64'(out_data_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_up_credit", 64'(upstream_credit), 0);
        chk("rst_rd_vld", 64'(read_data_vld), 0);
        chk("rst_irq", 64'({interrupt, irq_status}), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0; #1;
        chk("rdy_before_clock", 64'(write_rdy), 0);
        step();
        chk("rdy_after_clock", 64'({write_rdy, read_rdy}), 64'b11);

        // Vector table in IDLE; the router returns each credit in the same cycle
        for (int i = 0; i < 6; i++) begin
            step();
            write_en = tbl[i].we; write_addr = tbl[i].wa; write_data = tbl[i].wd;
            read_en = tbl[i].re; read_addr = tbl[i].ra; downstream_credit = tbl[i].exp_v;
            #1;
            chk($sformatf("tbl%0d_valid", i), 64'(out_data_valid), 64'(tbl[i].exp_v));
            if (tbl[i].exp_v) chk($sformatf("tbl%0d_flit", i), 64'(out_data), 64'(tbl[i].exp_f));
            chk($sformatf("tbl%0d_read_rdy", i), 64'(read_rdy), 64'(tbl[i].exp_rrdy));
            chk($sformatf("tbl%0d_write_rdy", i), 64'(write_rdy), 1);
        end

        // Random host traffic against a credit-window model
        m_credit = FD; m_rdy = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            we = 1'($urandom); re = 1'($urandom);
            wa = 16'($urandom_range(1, 16'hFFFE)); wd = 16'($urandom); ra = 16'($urandom);
            dc = (m_credit < FD) && 1'($urandom);
            write_en = we; write_addr = wa; write_data = wd;
            read_en = re; read_addr = ra; downstream_credit = dc;
            #1;
            wacc = we && m_rdy;
            racc = re && m_rdy && !we;
            ef = wacc ? mk(INFO_CONFIG, wa, wd) : mk(INFO_READ, ra, 16'h0);
            chk("rnd_write_rdy", 64'(write_rdy), 64'(m_rdy));
            chk("rnd_read_rdy", 64'(read_rdy), 64'(m_rdy && !we));
            chk("rnd_valid", 64'(out_data_valid), 64'(wacc || racc));
            if (wacc || racc) chk("rnd_flit", 64'(out_data), 64'(ef));
            m_credit = m_credit + int'(dc) - int'(wacc || racc);
            m_rdy = m_credit > 0;
        end
        give_credits(FD - m_credit);
        step();

        // Credit stall: 4 flits from a full window, then one returned credit
        fb = flits.size();
        for (int i = 0; i < 6; i++) begin
            host_wr(16'h0100 + 16'(i), 16'(i));
            #1;
            chk($sformatf("stall_rdy%0d", i), 64'(write_rdy), 64'(i < 4));
        end
        step();
        chk("stall_nflits", 64'(flits.size() - fb), 4);
        downstream_credit = 1;
        step();
        chk("stall_rdy_after_credit", 64'(write_rdy), 1);
        write_en = 1; write_addr = 16'h0200; write_data = 16'h0BEE;
        #1;
        chk("stall_fifth_valid", 64'(out_data_valid), 1);
        give_credits(FD);
        step();
        chk("stall_total", 64'(flits.size() - fb), 5);

        // Two-layer run with off-phase and unknown flits mixed in
        auto_on();
        fb = flits.size(); ub = up_cnt; ib = irq_cnt;
        host_wr(16'h0000, 16'h0002);
        host_wr(16'hFFFF, 16'h0000);
        for (int l = 0; l < 2; l++) begin
            step();
            chk($sformatf("run_busy_l%0d", l), 64'(busy), 1);
            chk($sformatf("run_layer_l%0d", l), 64'(layer_idx), 64'(l));
            send(INFO_FIN_CP, 1);
            send(4'hF, 1);
            send(INFO_FIN_BC, 64);
            send(INFO_FIN_BC, 1);
            send(INFO_FIN_CP, 64);
        end
        repeat (5) step();
        chk("run_nflits", 64'(flits.size() - fb), 6);
        if (flits.size() - fb == 6) begin
            chk("run_f0", 64'(flits[fb+0]), 64'(mk(INFO_CONFIG, 16'h0, 16'h2)));
            chk("run_f1", 64'(flits[fb+1]), 64'(mk(INFO_CALC, 16'h0, 16'h0)));
            chk("run_f2", 64'(flits[fb+2]), 64'(mk(INFO_FIN_BC, 16'h0, 16'h0)));
            chk("run_f3", 64'(flits[fb+3]), 64'(mk(INFO_FIN_CP, 16'h0, 16'h0)));
            chk("run_f4", 64'(flits[fb+4]), 64'(mk(INFO_FIN_BC, 16'h0, 16'h0)));
            chk("run_f5", 64'(flits[fb+5]), 64'(mk(INFO_FIN_CP, 16'h0, 16'h0)));
        end
        chk("run_irq_pulses", 64'(irq_cnt - ib), 1);
        chk("run_busy_end", 64'(busy), 0);
        chk("run_up_credits", 64'(up_cnt - ub), 2 * (3 + 64 + 64));
        repeat (5) step();
        chk("irq_sticky", 64'(irq_status), 1);
        irq_clr = 1;
        step();
        chk("irq_cleared", 64'(irq_status), 0);

        // Credit-starved completion: window drained before the 64th FIN_COMP
        auto_dc = 0;
        host_wr(16'h0000, 16'h0001);
        host_wr(16'h0005, 16'h0009);
        host_wr(16'hFFFF, 16'h0000);
        send(INFO_FIN_BC, 64);
        send(INFO_FIN_CP, 63);
        step(); in_data_valid = 1; in_data = mk(INFO_FIN_CP, 16'h0, 16'h0);
        #1;
        chk("starve_no_flit", 64'(out_data_valid), 0);
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            chk($sformatf("starve_wait_busy%0d", i), 64'(busy), 1);
            chk($sformatf("starve_wait_flit%0d", i), 64'(out_data_valid), 0);
        end
        step(); downstream_credit = 1; #1;
        chk("starve_credit_cycle", 64'(out_data_valid), 0);
        step(); #1;
        chk("starve_emit_valid", 64'(out_data_valid), 1);
        chk("starve_emit_flit", 64'(out_data), 64'(mk(INFO_FIN_CP, 16'h0, 16'h0)));
        step();
        chk("starve_interrupt", 64'(interrupt), 1);
        chk("starve_idle", 64'(busy), 0);
        give_credits(FD);
        step(); irq_clr = 1;
        step();

        // Read backpressure: three returns, host not ready for 10 cycles
        ub = up_cnt; rb = rd_q.size();
        for (int i = 0; i < 3; i++) begin
            step(); in_data_valid = 1; in_data = mk(INFO_READ, 16'h0005 + 16'(i), 16'hA005 + 16'(i));
        end
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("rd_hold_vld%0d", i), 64'(read_data_vld), 1);
            chk($sformatf("rd_hold_data%0d", i), 64'(read_data), 64'({12'h005, 16'hA005}));
        end
        chk("rd_credit_one_pop", 64'(up_cnt - ub), 1);
        read_data_rdy = 1;
        repeat (8) step();
        chk("rd_count", 64'(rd_q.size() - rb), 3);
        if (rd_q.size() - rb == 3) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("rd_order%0d", i), 64'(rd_q[rb+i]), 64'({12'h005 + 12'(i), 16'hA005 + 16'(i)}));
        end
        chk("rd_credits_total", 64'(up_cnt - ub), 3);
        chk("rd_vld_drained", 64'(read_data_vld), 0);

        // FIN flit consumed in the same cycle as a FIFO pop -> two back-to-back credits
        read_data_rdy = 0; rb = rd_q.size();
        step(); in_data_valid = 1; in_data = mk(INFO_READ, 16'h0011, 16'hB011);
        step(); in_data_valid = 1; in_data = mk(INFO_READ, 16'h0012, 16'hB012);
        repeat (4) step();
        sb = up_stamps.size();
        step(); read_data_rdy = 1; in_data_valid = 1; in_data = mk(INFO_FIN_BC, 16'h0, 16'h0);
        repeat (6) step();
        chk("dual_credit_count", 64'(up_stamps.size() - sb), 2);
        if (up_stamps.size() - sb == 2)
            chk("dual_credit_gap", 64'(up_stamps[sb+1] - up_stamps[sb]), 1);
        chk("dual_rd_count", 64'(rd_q.size() - rb), 2);

        // Abort mid-FIN_CP, then a full single-layer run still completes
        auto_on();
        ib = irq_cnt;
        host_wr(16'hFFFF, 16'h0000);
        send(INFO_FIN_BC, 64);
        send(INFO_FIN_CP, 10);
        step(); abort = 1; in_data_valid = 1; in_data = mk(INFO_FIN_CP, 16'h0, 16'h0);
        #1;
        chk("abort_no_flit", 64'(out_data_valid), 0);
        step();
        chk("abort_busy", 64'(busy), 0);
        chk("abort_layer", 64'(layer_idx), 0);
        chk("abort_write_rdy", 64'(write_rdy), 1);
        repeat (5) step();
        chk("abort_no_irq", 64'(irq_cnt - ib), 0);
        chk("abort_no_status", 64'(irq_status), 0);
        host_wr(16'hFFFF, 16'h0000);
        send(INFO_FIN_BC, 64);
        send(INFO_FIN_CP, 64);
        repeat (4) step();
        chk("rerun_irq", 64'(irq_cnt - ib), 1);
        chk("rerun_idle", 64'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
